counter_down_reload: RTL and testbench

Loadable down-counter and programmable divider for the CD-DSP timing chain: the decrementing counterpart of the team's up-counter. It counts a loaded value down to zero, emits a one-cycle terminal pulse, and then either reloads from a shadow register (periodic divide-by-N+1) or stops (one-shot). Sample-rate and subcode-frame timers use it where a period must be programmed at run time and retimed glitch-free.

---
 rtl/cd_dsp_pkg.sv | 9 +
 rtl/counter_down_reload.sv | 106 ++++++++++
 tb/tb_counter_down_reload.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cd_dsp_pkg.sv
// Shared types for the CD-DSP timing chain blocks.
package cd_dsp_pkg;

    typedef enum logic {
        CDR_IDLE = 1'b0,
        CDR_RUN  = 1'b1
    } cdr_state_t;

endpackage : cd_dsp_pkg

// File: rtl/counter_down_reload.sv
// Loadable down-counter / divider: counts a loaded value to zero, pulses terminal,
// then reloads from a shadow register (periodic) or stops (one-shot).
module counter_down_reload
    import cd_dsp_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] VAL_RST     = '0,
    parameter bit                    AUTO_RELOAD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  clkInhibit,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] loadVal,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  terminal,
    output logic                  busy,
    output logic                  pending
);

    localparam logic [DATA_WIDTH-1:0] CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    cdr_state_t            state_reg;
    cdr_state_t            state_next;
    logic [DATA_WIDTH-1:0] count_reg;
    logic [DATA_WIDTH-1:0] count_next;
    logic [DATA_WIDTH-1:0] reload_reg;
    logic [DATA_WIDTH-1:0] reload_val;
    logic                  pending_reg;
    logic                  terminal_reg;
    logic                  term_hit;

    // An aborting stop suppresses the terminal pulse even when the count is already zero.
    assign term_hit   = (state_reg == CDR_RUN) && !clkInhibit && !stop && (count_reg == '0);
    // A load on the terminal edge bypasses the shadow register so the new period applies at once.
    assign reload_val = load ? loadVal : reload_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            CDR_IDLE: begin
                if (load) begin
                    count_next = loadVal;
                end
                if (start && !stop) begin
                    state_next = CDR_RUN;
                end
            end
            CDR_RUN: begin
                if (stop) begin
                    state_next = CDR_IDLE;
                end else if (!clkInhibit) begin
                    if (count_reg != '0) begin
                        count_next = count_reg - CNT_ONE;
                    end else if (AUTO_RELOAD) begin
                        count_next = reload_val;
                    end else begin
                        state_next = CDR_IDLE;
                    end
                end
            end
            default: begin
                state_next = CDR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg    <= CDR_IDLE;
            count_reg    <= VAL_RST;
            terminal_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            terminal_reg <= term_hit;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            reload_reg  <= VAL_RST;
            pending_reg <= 1'b0;
        end else begin
            if (load) begin
                reload_reg <= loadVal;
            end
            if (term_hit) begin
                pending_reg <= 1'b0;
            end else if (load && (state_reg == CDR_RUN)) begin
                pending_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        busy     = (state_reg == CDR_RUN);
        out      = count_reg;
        terminal = terminal_reg;
        pending  = pending_reg;
    end

endmodule : counter_down_reload

// File: tb/tb_counter_down_reload.sv
// Directed bench for counter_down_reload: periodic instance and one-shot instance share stimulus.
module tb_counter_down_reload;

    logic       clk;
    logic       rstN;
    logic       clkInhibit;
    logic       load;
    logic [7:0] loadVal;
    logic       start;
    logic       stop;

    logic [7:0] out_ar;
    logic       term_ar;
    logic       busy_ar;
    logic       pend_ar;
    logic [7:0] out_os;
    logic       term_os;
    logic       busy_os;
    logic       pend_os;

    int errors = 0;
    int checks = 0;

    counter_down_reload #(.DATA_WIDTH(8), .VAL_RST(8'd0), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rstN(rstN), .clkInhibit(clkInhibit), .load(load), .loadVal(loadVal),
        .start(start), .stop(stop), .out(out_ar), .terminal(term_ar), .busy(busy_ar),
        .pending(pend_ar)
    );

    counter_down_reload #(.DATA_WIDTH(8), .VAL_RST(8'd0), .AUTO_RELOAD(1'b0)) dut_os (
        .clk(clk), .rstN(rstN), .clkInhibit(clkInhibit), .load(load), .loadVal(loadVal),
        .start(start), .stop(stop), .out(out_os), .terminal(term_os), .busy(busy_os),
        .pending(pend_os)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clkInhibit = 1'b0;
        load       = 1'b0;
        loadVal    = 8'd0;
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstN = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
        tick();
    endtask

    // load v then start, leaving out==v and busy on return
    task automatic load_and_start(input logic [7:0] v);
        load = 1'b1; loadVal = v;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_ar !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out_ar); end
        checks++; if (busy_ar !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_ar); end
        checks++; if (term_ar !== 1'b0) begin errors++; $display("FAIL reset_term: got %0b expected 0", term_ar); end
        checks++; if (pend_ar !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b expected 0", pend_ar); end
        load_and_start(8'd7);
        tick();
        tick();
        checks++; if (out_ar !== 8'd5) begin errors++; $display("FAIL midcount_out: got %0d expected 5", out_ar); end
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (out_ar !== 8'd0) begin errors++; $display("FAIL async_reset_out: got %0d expected 0", out_ar); end
        checks++; if (busy_ar !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %0b expected 0", busy_ar); end
        checks++; if (term_ar !== 1'b0) begin errors++; $display("FAIL async_reset_term: got %0b expected 0", term_ar); end
        rstN = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_periodic();
        logic [7:0] exp_out [12] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
        do_reset();
        load = 1'b1; loadVal = 8'd3;
        tick();
        load = 1'b0;
        checks++; if (out_ar !== 8'd3) begin errors++; $display("FAIL periodic_load: got %0d expected 3", out_ar); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_ar !== 8'd3) begin errors++; $display("FAIL periodic_start_out: got %0d expected 3", out_ar); end
        checks++; if (busy_ar !== 1'b1) begin errors++; $display("FAIL periodic_busy: got %0b expected 1", busy_ar); end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (out_ar !== exp_out[i]) begin errors++; $display("FAIL periodic_out[%0d]: got %0d expected %0d", i, out_ar, exp_out[i]); end
            checks++;
            if (term_ar !== ((i % 4) == 3)) begin errors++; $display("FAIL periodic_term[%0d]: got %0b expected %0b", i, term_ar, ((i % 4) == 3)); end
        end
        $display("test_periodic done");
    endtask

    task automatic test_inhibit();
        logic [7:0] exp_out [8]  = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd2};
        logic       exp_inh [8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_term [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        load_and_start(8'd3);
        for (int i = 0; i < 8; i++) begin
            clkInhibit = exp_inh[i];
            tick();
            checks++;
            if (out_ar !== exp_out[i] || term_ar !== exp_term[i]) begin
                errors++;
                $display("FAIL inhibit[%0d]: got out=%0d term=%0b expected out=%0d term=%0b",
                         i, out_ar, term_ar, exp_out[i], exp_term[i]);
            end
        end
        clkInhibit = 1'b0;
        $display("test_inhibit done");
    endtask

    task automatic test_pending();
        do_reset();
        load_and_start(8'd3);
        tick();
        load = 1'b1; loadVal = 8'd1;
        tick();
        load = 1'b0;
        checks++; if (out_ar !== 8'd1 || pend_ar !== 1'b1) begin errors++; $display("FAIL pending_set: got out=%0d pend=%0b expected out=1 pend=1", out_ar, pend_ar); end
        tick();
        checks++; if (out_ar !== 8'd0 || pend_ar !== 1'b1) begin errors++; $display("FAIL pending_hold: got out=%0d pend=%0b expected out=0 pend=1", out_ar, pend_ar); end
        tick();
        checks++; if (out_ar !== 8'd1 || term_ar !== 1'b1 || pend_ar !== 1'b0) begin errors++; $display("FAIL pending_apply: got out=%0d term=%0b pend=%0b expected out=1 term=1 pend=0", out_ar, term_ar, pend_ar); end
        tick();
        checks++; if (out_ar !== 8'd0 || term_ar !== 1'b0) begin errors++; $display("FAIL pending_p2a: got out=%0d term=%0b expected out=0 term=0", out_ar, term_ar); end
        tick();
        checks++; if (out_ar !== 8'd1 || term_ar !== 1'b1) begin errors++; $display("FAIL pending_p2b: got out=%0d term=%0b expected out=1 term=1", out_ar, term_ar); end
        $display("test_pending done");
    endtask

    task automatic test_oneshot();
        do_reset();
        load_and_start(8'd2);
        tick();
        tick();
        checks++; if (out_os !== 8'd0 || term_os !== 1'b0 || busy_os !== 1'b1) begin errors++; $display("FAIL oneshot_zero: got out=%0d term=%0b busy=%0b expected 0/0/1", out_os, term_os, busy_os); end
        tick();
        checks++; if (out_os !== 8'd0 || term_os !== 1'b1 || busy_os !== 1'b0) begin errors++; $display("FAIL oneshot_done: got out=%0d term=%0b busy=%0b expected 0/1/0", out_os, term_os, busy_os); end
        tick();
        checks++; if (term_os !== 1'b0 || busy_os !== 1'b0) begin errors++; $display("FAIL oneshot_idle: got term=%0b busy=%0b expected 0/0", term_os, busy_os); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy_os !== 1'b1 || term_os !== 1'b0) begin errors++; $display("FAIL oneshot_restart: got busy=%0b term=%0b expected 1/0", busy_os, term_os); end
        tick();
        checks++; if (term_os !== 1'b1 || busy_os !== 1'b0) begin errors++; $display("FAIL oneshot_zero_start: got term=%0b busy=%0b expected 1/0", term_os, busy_os); end
        $display("test_oneshot done");
    endtask

    task automatic test_stop_start();
        do_reset();
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        checks++; if (busy_ar !== 1'b0) begin errors++; $display("FAIL stop_start_idle: got busy=%0b expected 0", busy_ar); end
        load_and_start(8'd3);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (out_ar !== 8'd2 || busy_ar !== 1'b0 || term_ar !== 1'b0) begin errors++; $display("FAIL stop_run: got out=%0d busy=%0b term=%0b expected 2/0/0", out_ar, busy_ar, term_ar); end
        $display("test_stop_start done");
    endtask

    task automatic test_zero_reload();
        do_reset();
        load_and_start(8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (term_ar !== 1'b1 || out_ar !== 8'd0) begin errors++; $display("FAIL zero_reload[%0d]: got out=%0d term=%0b expected 0/1", i, out_ar, term_ar); end
        end
        $display("test_zero_reload done");
    endtask

    task automatic test_load_at_terminal();
        do_reset();
        load_and_start(8'd2);
        tick();
        tick();
        load = 1'b1; loadVal = 8'd5;
        tick();
        load = 1'b0;
        checks++; if (out_ar !== 8'd5 || term_ar !== 1'b1 || pend_ar !== 1'b0) begin errors++; $display("FAIL load_at_term: got out=%0d term=%0b pend=%0b expected 5/1/0", out_ar, term_ar, pend_ar); end
        tick();
        checks++; if (out_ar !== 8'd4 || pend_ar !== 1'b0) begin errors++; $display("FAIL load_at_term_next: got out=%0d pend=%0b expected 4/0", out_ar, pend_ar); end
        $display("test_load_at_terminal done");
    endtask

    initial begin
        rstN = 1'b1;
        idle_inputs();
        test_reset();
        test_periodic();
        test_inhibit();
        test_pending();
        test_oneshot();
        test_stop_start();
        test_zero_reload();
        test_load_at_terminal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_down_reload
